// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, sticky completion/error flags and a level delete strobe.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive rx_parity_error.
`timescale 1ns/1ps
module uart_rx_core #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           baudselect,
   input  logic                 RXD,
   input  logic                 rx_complete_del_flag,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_complete_flag,
   output logic                 rx_busy,
   output logic                 rx_overrun,
   output logic                 rx_frame_error,
   output logic                 rx_parity_error
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_nxt;
   logic                 rxd_meta, rxd_s;
   logic [9:0]           tick_cnt;
   logic                 tick;
   logic [SW-1:0]        samp_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 shift_en, stop_good, stop_bad;

   // >= rather than == so a lowered divisor never waits for a 10-bit wrap
   assign tick = (baudselect <= 10'd1) || (tick_cnt >= baudselect - 10'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
         tick_cnt <= '0;
      end else begin
         rxd_meta <= RXD;
         rxd_s    <= rxd_meta;
         tick_cnt <= tick ? 10'd0 : tick_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            IDLE:   if (!rxd_s) state_nxt = START;
            START:  if (samp_cnt == S_MID) state_nxt = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (samp_cnt == S_END && bit_cnt == B_LAST) state_nxt = PARITY;
            PARITY: if (samp_cnt == S_END) state_nxt = STOP;
`else
            DATA:   if (samp_cnt == S_END && bit_cnt == B_LAST) state_nxt = STOP;
`endif
            STOP:   if (samp_cnt == S_END) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      shift_en  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      if (tick && samp_cnt == S_END) begin
         case (state)
            DATA:    shift_en = 1'b1;
            STOP:    begin stop_good = rxd_s; stop_bad = !rxd_s; end
            default: ;
         endcase
      end
   end

   // Sample counter restarts at start detection and again at mid start bit,
   // so every later sample lands 16 ticks apart near mid-bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         samp_cnt <= '0;
         bit_cnt  <= '0;
      end else if (tick) begin
         if (state == IDLE || (state == START && samp_cnt == S_MID)) samp_cnt <= '0;
         else                                                        samp_cnt <= samp_cnt + SW'(1);
         if (state == START) bit_cnt <= '0;
         else if (shift_en)  bit_cnt <= bit_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg            <= '0;
         rx_data          <= '0;
         rx_complete_flag <= 1'b0;
         rx_overrun       <= 1'b0;
         rx_frame_error   <= 1'b0;
         rx_busy          <= 1'b0;
      end else begin
         rx_busy <= (state_nxt != IDLE);
         if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
         if (rx_complete_del_flag) begin
            rx_complete_flag <= 1'b0;
            rx_overrun       <= 1'b0;
            rx_frame_error   <= 1'b0;
         end
         if (stop_good) begin
            rx_data          <= shreg;
            rx_complete_flag <= 1'b1;
            if (rx_complete_flag) rx_overrun <= 1'b1;
         end
         if (stop_bad) rx_frame_error <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   always_ff @(posedge clk) begin
      if (reset) begin
         par_bit         <= 1'b0;
         rx_parity_error <= 1'b0;
      end else begin
         if (tick && samp_cnt == S_END && state == PARITY) par_bit <= rxd_s;
         if (rx_complete_del_flag) rx_parity_error <= 1'b0;
         if (stop_good && ((^shreg) != par_bit)) rx_parity_error <= 1'b1;
      end
   end
`else
   assign rx_parity_error = 1'b0;
`endif

endmodule
